// File: rtl/regfile_pkg.sv
// Shared register-file definitions: index/data widths, well-known register
// indices and the writeback request payload used by writeback requesters.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO  = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP    = 5'd2;
  localparam logic [REG_ADDR_W-1:0] REG_CYCLE = 5'd30;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between N_REQ requesters and the register-file write port.
//   master : requester side (drives req_*, observes ready and write port)
//   slave  : arbiter side   (drives req_ready and the registered write port)
// Requester i occupies req_dst[i*ADDR_W +: ADDR_W] and req_data[i*DATA_W +: DATA_W].
interface regfile_wb_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = regfile_pkg::REG_DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::REG_ADDR_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_dst;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       wb;
  logic [ADDR_W-1:0]       dst;
  logic                    reg_write;

  modport master (
    output req_valid, req_dst, req_data,
    input  req_ready, wb, dst, reg_write
  );

  modport slave (
    input  req_valid, req_dst, req_data,
    output req_ready, wb, dst, reg_write
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index for this cycle (must be < N)
//   gnt     : one-hot grant to the first requester at or after ptr (wrapping)
//   gnt_idx : binary index of the granted requester (0 when none)
module rr_arbiter #(
  parameter  int unsigned N     = 3,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W:0] pos;
  logic           found;

  // Walk N slots starting at ptr; first active request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      if (!found && req[pos[IDX_W-1:0]]) begin
        found                 = 1'b1;
        gnt[pos[IDX_W-1:0]]   = 1'b1;
        gnt_idx               = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// N_REQ writeback requesters, with a registered write port and a saturating
// contention counter.
//   CLOCK_50     : clock, all state on rising edge
//   reset_n      : synchronous active-low reset
//   bus          : writeback bus (slave side): req_valid/req_dst/req_data in,
//                  req_ready (one-hot, comb) and wb/dst/reg_write (registered) out
//   conflict_cnt : cycles with two or more valid requests, saturating
// Optional macro REGARB_BYPASS_EN adds byp_addr_a/b inputs and
// byp_hit_a/b/byp_data outputs that expose the in-flight write for forwarding.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  regfile_wb_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]     conflict_cnt
`ifdef REGARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]    byp_addr_a,
  input  logic [ADDR_W-1:0]    byp_addr_b,
  output logic                 byp_hit_a,
  output logic                 byp_hit_b,
  output logic [DATA_W-1:0]    byp_data
`endif
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]              rr_ptr;
  logic [N_REQ-1:0]              gnt;
  logic [IDX_W-1:0]              gnt_idx;
  logic                          xfer;
  logic                          multi_valid;
  logic [N_REQ-1:0][ADDR_W-1:0]  dst_arr;
  logic [N_REQ-1:0][DATA_W-1:0]  data_arr;
  logic [DATA_W-1:0]             wb_q;
  logic [ADDR_W-1:0]             dst_q;
  logic                          reg_write_q;
  logic [CNT_W-1:0]              cnt_q;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is masked during reset so nothing is accepted in a reset cycle.
  assign bus.req_ready = gnt & {N_REQ{reset_n}};
  assign xfer          = |bus.req_ready;

  assign dst_arr  = bus.req_dst;
  assign data_arr = bus.req_data;

  // Clearing the lowest set bit leaves a non-zero value iff two or more bits are set.
  assign multi_valid = (bus.req_valid & (bus.req_valid - N_REQ'(1))) != '0;

  // Write port register, round-robin pointer and contention counter.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      wb_q        <= '0;
      dst_q       <= '0;
      reg_write_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      reg_write_q <= 1'b0;
      if (xfer) begin
        wb_q        <= data_arr[gnt_idx];
        dst_q       <= dst_arr[gnt_idx];
        // x0 writes are accepted but never reach the register file.
        reg_write_q <= dst_arr[gnt_idx] != ADDR_W'(REG_ZERO);
        rr_ptr      <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      if (multi_valid && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.wb        = wb_q;
  assign bus.dst       = dst_q;
  assign bus.reg_write = reg_write_q;
  assign conflict_cnt  = cnt_q;

`ifdef REGARB_BYPASS_EN
  // Expose the write currently on the port so decode can forward it.
  assign byp_hit_a = reg_write_q & (dst_q == byp_addr_a) & (dst_q != '0);
  assign byp_hit_b = reg_write_q & (dst_q == byp_addr_b) & (dst_q != '0);
  assign byp_data  = wb_q;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (wb, dst, reg_write) between N_REQ writeback requesters, e.g. ALU, load unit and CSR/mult unit.
- Uses a round-robin arbiter with a valid/ready handshake per requester. Write-port outputs are registered.
- Keeps a saturating contention counter for performance debug.
- Sits between the execute/memory stages and the register file.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, writeback data width
- ADDR_W, 5, register index width
- CNT_W, 16, contention counter width

Ports:
- CLOCK_50  input  1  system clock, all state on rising edge
- reset_n  input  1  synchronous, active-low reset
- req_valid  input  N_REQ  per-requester write request
- req_dst  input  N_REQ*ADDR_W  destination index, requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  input  N_REQ*DATA_W  write data, requester i at bits [i*DATA_W +: DATA_W]
- req_ready  output  N_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- wb  output  DATA_W  write data to the register file
- dst  output  ADDR_W  write index to the register file
- reg_write  output  1  write enable to the register file
- conflict_cnt  output  CNT_W  cycles with more than one valid request, saturating

Behaviour:
- Reset (reset_n low at a clock edge):
  - wb=0, dst=0, reg_write=0, conflict_cnt=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is forced to 0 combinationally while reset_n is low, so no transfer is accepted during reset.
- Reset asserted mid-transfer: a write registered in the previous cycle still appears at the regfile that cycle; the next edge clears reg_write. A grant in the reset cycle is not a transfer.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, wrapping modulo N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - No valid requests gives req_ready=0.
  - Ready depends only on req_valid and rr_ptr, so there is no combinational path from req_dst or req_data.
- Pointer update: on a transfer by requester g, rr_ptr <= (g+1) mod N_REQ. With no transfer, rr_ptr holds.
- Starvation bound: a continuously valid requester is granted within N_REQ cycles.
- Requester rule: once raised, req_valid, req_dst and req_data must stay stable until the transfer. The arbiter does not check this.
- Output register, one-cycle latency:
  - On a transfer: wb <= req_data[g], dst <= req_dst[g], reg_write <= (req_dst[g] != 0).
  - A write to x0 is still accepted (ready asserted, pointer advances) but produces reg_write=0.
  - With no transfer: reg_write <= 0. wb and dst hold their previous values (don't-care to the regfile).
- Throughput: one write per cycle sustained, with no bubbles between back-to-back grants.
- conflict_cnt:
  - Increments on every non-reset cycle where popcount(req_valid) >= 2.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Duplicate destinations: two requesters targeting the same dst are serialized in grant order; the later grant's data is the final register value.

Optional Feature:
- Macro: REGARB_BYPASS_EN.
- With the macro defined, these ports are added:
  - byp_addr_a, byp_addr_b  input  ADDR_W each
  - byp_hit_a, byp_hit_b  output  1 each
  - byp_data  output  DATA_W
- Bypass behaviour:
  - byp_hit_x = reg_write & (dst == byp_addr_x) & (dst != 0), combinational.
  - byp_data = wb.
  - This lets decode forward a write that is in flight on the port this cycle.
- Without the macro: the ports are absent and no bypass logic is present.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32
  - REG_ZERO=5'd0, REG_SP=5'd2, REG_CYCLE=5'd30
  - typedef wb_req_t {dst, data}
- One sub-module, rr_arbiter (N parameter; inputs req, ptr; output one-hot gnt and binary gnt_idx), holds the arbitration; the top handles registers and counters.

Test Plan:
- Single request, then wb register order: reset, then req_valid=3'b001, dst=5, data=32'hDEADBEEF for one cycle.
  - req_ready=3'b001 that cycle.
  - The next cycle shows reg_write=1, dst=5, wb=DEADBEEF, and the regfile's reg 5 reads DEADBEEF the cycle after.
- All valid held 6 cycles: all three requesters valid with dsts 1, 3, 4 held until their own grant, reissuing after each grant.
  - Grant sequence is 0,1,2,0,1,2.
  - reg_write is high on 6 consecutive cycles.
  - conflict_cnt=6.
- x0 write: requester 1 writes dst=0, data=32'h1234.
  - req_ready[1]=1 and rr_ptr moves to 2, but reg_write stays 0.
  - The regfile's reg 0 remains 0.
- Reset mid-stream: all requesters valid; drop reset_n for one cycle after the 2nd grant.
  - req_ready=0 in the reset cycle.
  - Next cycle: reg_write=0, conflict_cnt=0, and the first grant afterwards goes to requester 0.
- Saturation, with CNT_W=4: two requesters valid for 20 cycles.
  - conflict_cnt reaches 15 and stays at 15.
- Bypass, with REGARB_BYPASS_EN: a transfer to dst=7 with byp_addr_a=7 and byp_addr_b=8.
  - Next cycle: byp_hit_a=1, byp_hit_b=0, byp_data equals the written data.
  - With dst=0, byp_hit_a stays 0.
